// File: rtl/select_mask_tx.sv
// select_mask_tx: per-channel selection mask builder and serialiser.
//
// Software writes single channel bits into a shadow mask. A commit snapshots
// the shadow and streams it out as NUM_WORDS 32-bit words, word k carrying
// channels 32k+31..32k, with tlast on the final word.
//
// Optional build macro SELECT_MASK_TX_CLEAR_ALL_EN adds a clear_all input that
// zeroes the whole shadow mask in one clock (a same-cycle bit write still lands).
//
// state | meaning
// IDLE  | no packet on the stream, waiting for commit
// SEND  | snapshot being streamed; a commit here is held as pending
module select_mask_tx #(
  parameter int CHAN_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  sync_reset,
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
  input  logic                  clear_all,
`endif
  input  logic                  bit_wr_valid,
  input  logic [CHAN_WIDTH-1:0] bit_wr_chan,
  input  logic                  bit_wr_value,
  input  logic                  commit,
  output logic                  busy,
  output logic                  m_axis_select_tvalid,
  output logic [31:0]           m_axis_select_tdata,
  output logic                  m_axis_select_tlast,
  input  logic                  m_axis_select_tready
);

  localparam int NUM_CHAN  = 2 ** CHAN_WIDTH;
  localparam int NUM_WORDS = 2 ** (CHAN_WIDTH - 5);
  localparam int CNT_W     = CHAN_WIDTH - 5;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [NUM_CHAN-1:0]   shadow_q, shadow_d;
  logic [NUM_CHAN-1:0]   snap_q, snap_d;
  logic                  snap_load;
  logic                  tvalid_q, tvalid_d;
  logic [31:0]           tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic                  beat_acc;

  assign beat_acc = tvalid_q & m_axis_select_tready;

  // Shadow next value: optional clear first, then the single-bit write on top,
  // so a commit in the same cycle sees both.
  always_comb begin
    shadow_d = shadow_q;
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
    if (clear_all) begin
      shadow_d = '0;
    end
`endif
    if (bit_wr_valid) begin
      shadow_d[bit_wr_chan] = bit_wr_value;
    end
  end

  // Shadow mask register; writes are accepted in every state.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      shadow_q <= '0;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  // FSM state, word counter and pending-commit flag.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  // Next-state logic. A packet is never cut short: commits during SEND are
  // remembered and relaunch the stream right after the tlast beat, with no gap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit) begin
          state_d   = SEND;
          cnt_d     = '0;
          snap_load = 1'b1;
        end
      end
      SEND: begin
        if (commit) begin
          pending_d = 1'b1;
        end
        if (beat_acc) begin
          if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
            if (pending_q || commit) begin
              // A commit on the tlast-accept cycle is served by this relaunch.
              snap_load = 1'b1;
              pending_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Snapshot next value: reloaded from the updated shadow only on launch.
  always_comb begin
    snap_d = snap_q;
    if (snap_load) begin
      snap_d = shadow_d;
    end
  end

  // Transmit snapshot register; isolated from later shadow writes.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      snap_q <= '0;
    end else begin
      snap_q <= snap_d;
    end
  end

  // Output decode from the next state, so the stream outputs can be registered
  // and hold steady under backpressure (next values equal current values).
  always_comb begin
    tvalid_d = (state_d == SEND);
    tlast_d  = 1'b0;
    tdata_d  = '0;
    if (tvalid_d) begin
      tlast_d = (cnt_d == LAST_CNT);
      tdata_d = snap_d[{cnt_d, 5'b00000} +: 32];
    end
  end

  // Registered stream outputs; reset drops tvalid immediately.
  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
    end
  end

  assign m_axis_select_tvalid = tvalid_q;
  assign m_axis_select_tdata  = tdata_q;
  assign m_axis_select_tlast  = tlast_q;
  assign busy                 = (state_q == SEND) | pending_q;

endmodule

// File: tb/tb_select_mask_tx.sv
// Directed testbench for select_mask_tx (default 2048-channel build).
module tb_select_mask_tx;

  logic        clk = 1'b0;
  logic        sync_reset;
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
  logic        clear_all;
`endif
  logic        bit_wr_valid;
  logic [10:0] bit_wr_chan;
  logic        bit_wr_value;
  logic        commit;
  logic        busy;
  logic        m_axis_select_tvalid;
  logic [31:0] m_axis_select_tdata;
  logic        m_axis_select_tlast;
  logic        m_axis_select_tready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  select_mask_tx #(.CHAN_WIDTH(11)) dut (
    .clk                  (clk),
    .sync_reset           (sync_reset),
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
    .clear_all            (clear_all),
`endif
    .bit_wr_valid         (bit_wr_valid),
    .bit_wr_chan          (bit_wr_chan),
    .bit_wr_value         (bit_wr_value),
    .commit               (commit),
    .busy                 (busy),
    .m_axis_select_tvalid (m_axis_select_tvalid),
    .m_axis_select_tdata  (m_axis_select_tdata),
    .m_axis_select_tlast  (m_axis_select_tlast),
    .m_axis_select_tready (m_axis_select_tready)
  );

  // Inputs change and outputs are sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bit(input int chan, input logic val);
    bit_wr_valid = 1'b1;
    bit_wr_chan  = 11'(chan);
    bit_wr_value = val;
    tick();
    bit_wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic test_reset();
    sync_reset = 1'b1;
    #1;
    n_cmp++;
    if (m_axis_select_tvalid !== 1'b0 || m_axis_select_tlast !== 1'b0 ||
        m_axis_select_tdata !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got tvalid=%b tlast=%b tdata=%h busy=%b, want all 0",
               m_axis_select_tvalid, m_axis_select_tlast, m_axis_select_tdata, busy);
    end
    tick();
    tick();
    sync_reset = 1'b0;
    tick();
  endtask

  // Mask bits 0, 33, 2047 streamed with tready held high.
  task automatic test_basic();
    logic [31:0] exp_w;
    wr_bit(0, 1'b1);
    wr_bit(33, 1'b1);
    wr_bit(2047, 1'b1);
    m_axis_select_tready = 1'b1;
    pulse_commit();
    for (int k = 0; k < 64; k++) begin
      exp_w = (k == 0) ? 32'h0000_0001 : (k == 1) ? 32'h0000_0002 :
              (k == 63) ? 32'h8000_0000 : 32'h0;
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== exp_w ||
          m_axis_select_tlast !== (k == 63) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL basic_beat%0d: got v=%b d=%h l=%b busy=%b, want v=1 d=%h l=%b busy=1",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast, busy,
                 exp_w, (k == 63));
      end
      tick();
    end
    n_cmp++;
    if (m_axis_select_tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: got tvalid=%b busy=%b, want 0 0", m_axis_select_tvalid, busy);
    end
  endtask

  // Same mask with tready alternating; outputs must hold while stalled.
  task automatic test_stall();
    logic [31:0] exp_w;
    logic [31:0] prev_d;
    logic        prev_l;
    logic        prev_stall;
    int          k;
    int          cyc;
    k = 0;
    cyc = 0;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    pulse_commit();
    while (k < 64 && cyc < 400) begin
      exp_w = (k == 0) ? 32'h0000_0001 : (k == 1) ? 32'h0000_0002 :
              (k == 63) ? 32'h8000_0000 : 32'h0;
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== exp_w ||
          m_axis_select_tlast !== (k == 63)) begin
        n_fail++;
        $display("FAIL stall_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast,
                 exp_w, (k == 63));
      end
      if (prev_stall) begin
        n_cmp++;
        if (m_axis_select_tdata !== prev_d || m_axis_select_tlast !== prev_l) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got d=%h l=%b, want d=%h l=%b",
                   k, m_axis_select_tdata, m_axis_select_tlast, prev_d, prev_l);
        end
      end
      m_axis_select_tready = (cyc % 2 == 0);
      prev_stall = !m_axis_select_tready;
      prev_d = m_axis_select_tdata;
      prev_l = m_axis_select_tlast;
      if (m_axis_select_tready) k++;
      cyc++;
      tick();
    end
    m_axis_select_tready = 1'b1;
    n_cmp++;
    if (k != 64 || m_axis_select_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: got beats=%0d tvalid=%b, want 64 0", k, m_axis_select_tvalid);
    end
  endtask

  // Commits at beats 10 and 20, chan 64 written at beat 15: one extra packet.
  task automatic test_back_to_back();
    logic [31:0] exp_w;
    int w;
    m_axis_select_tready = 1'b1;
    pulse_commit();
    for (int k = 0; k < 128; k++) begin
      w = k % 64;
      exp_w = (w == 0) ? 32'h0000_0001 : (w == 1) ? 32'h0000_0002 :
              (w == 63) ? 32'h8000_0000 : (w == 2 && k >= 64) ? 32'h0000_0001 : 32'h0;
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== exp_w ||
          m_axis_select_tlast !== (w == 63) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_beat%0d: got v=%b d=%h l=%b busy=%b, want v=1 d=%h l=%b busy=1",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast, busy,
                 exp_w, (w == 63));
      end
      commit = (k == 10 || k == 20);
      bit_wr_valid = (k == 15);
      bit_wr_chan = 11'd64;
      bit_wr_value = 1'b1;
      tick();
      commit = 1'b0;
      bit_wr_valid = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_idle%0d: got tvalid=%b busy=%b, want 0 0",
                 i, m_axis_select_tvalid, busy);
      end
      tick();
    end
  endtask

  // From a cleared mask, write chan 5 and commit on the same clock.
  task automatic test_same_cycle_commit();
    logic [31:0] exp_w;
    sync_reset = 1'b1;
    tick();
    sync_reset = 1'b0;
    tick();
    bit_wr_valid = 1'b1;
    bit_wr_chan  = 11'd5;
    bit_wr_value = 1'b1;
    commit       = 1'b1;
    tick();
    bit_wr_valid = 1'b0;
    commit       = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_w = (k == 0) ? 32'h0000_0020 : 32'h0;
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== exp_w ||
          m_axis_select_tlast !== (k == 63)) begin
        n_fail++;
        $display("FAIL samecyc_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast,
                 exp_w, (k == 63));
      end
      tick();
    end
  endtask

  // Reset at beat 30 drops the stream at once; a later empty commit sends zeros.
  task automatic test_reset_mid_packet();
    pulse_commit();
    for (int k = 0; k < 30; k++) tick();
    n_cmp++;
    if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst_pre: got v=%b d=%h, want v=1 d=00000000",
               m_axis_select_tvalid, m_axis_select_tdata);
    end
    sync_reset = 1'b1;
    #1;
    n_cmp++;
    if (m_axis_select_tvalid !== 1'b0 || busy !== 1'b0 || m_axis_select_tlast !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_drop: got tvalid=%b busy=%b tlast=%b, want 0 0 0",
               m_axis_select_tvalid, busy, m_axis_select_tlast);
    end
    tick();
    sync_reset = 1'b0;
    tick();
    pulse_commit();
    for (int k = 0; k < 64; k++) begin
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== 32'h0 ||
          m_axis_select_tlast !== (k == 63)) begin
        n_fail++;
        $display("FAIL midrst_beat%0d: got v=%b d=%h l=%b, want v=1 d=00000000 l=%b",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast, (k == 63));
      end
      tick();
    end
    n_cmp++;
    if (m_axis_select_tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_end: got tvalid=%b, want 0", m_axis_select_tvalid);
    end
  endtask

`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
  // clear_all with a concurrent chan 7 write leaves only chan 7 set.
  task automatic test_clear_all();
    logic [31:0] exp_w;
    wr_bit(1, 1'b1);
    wr_bit(40, 1'b1);
    clear_all    = 1'b1;
    bit_wr_valid = 1'b1;
    bit_wr_chan  = 11'd7;
    bit_wr_value = 1'b1;
    tick();
    clear_all    = 1'b0;
    bit_wr_valid = 1'b0;
    pulse_commit();
    for (int k = 0; k < 64; k++) begin
      exp_w = (k == 0) ? 32'h0000_0080 : 32'h0;
      n_cmp++;
      if (m_axis_select_tvalid !== 1'b1 || m_axis_select_tdata !== exp_w ||
          m_axis_select_tlast !== (k == 63)) begin
        n_fail++;
        $display("FAIL clear_beat%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 k, m_axis_select_tvalid, m_axis_select_tdata, m_axis_select_tlast,
                 exp_w, (k == 63));
      end
      tick();
    end
  endtask
`endif

  initial begin
    sync_reset           = 1'b1;
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
    clear_all            = 1'b0;
`endif
    bit_wr_valid         = 1'b0;
    bit_wr_chan          = '0;
    bit_wr_value         = 1'b0;
    commit               = 1'b0;
    m_axis_select_tready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_same_cycle_commit();
    test_reset_mid_packet();
`ifdef SELECT_MASK_TX_CLEAR_ALL_EN
    test_clear_all();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/select_mask_tx.md
Name: select_mask_tx

Overview:
- Builds a per-channel selection mask from single-bit channel writes.
- On a commit, serialises the mask onto the 32-bit select FIFO stream consumed by the channelizer downselection stage.
- Packet format: word k carries channels 32k+31..32k; tlast is set on the final word.
- Sits between the control/register path and the channelizer select input. Lets software update individual channels without rebuilding the whole mask.

Parameters:
- CHAN_WIDTH, 11, channel index width. Channel count is 2^CHAN_WIDTH.
- NUM_WORDS, 64 (localparam, derived as 2^(CHAN_WIDTH-5)), words per mask packet. CHAN_WIDTH must be >= 6.

Ports:
- clk  in  1  clock
- sync_reset  in  1  reset, asynchronous, active-high
- bit_wr_valid  in  1  single-channel write strobe
- bit_wr_chan  in  CHAN_WIDTH  channel index to write
- bit_wr_value  in  1  1 = keep channel, 0 = drop channel
- commit  in  1  snapshot shadow mask and transmit
- busy  out  1  packet in flight or pending
- m_axis_select_tvalid  out  1  select stream valid
- m_axis_select_tdata  out  32  mask word
- m_axis_select_tlast  out  1  last word of mask packet
- m_axis_select_tready  in  1  downstream ready

Behaviour:
- Interface decided: clock clk; reset sync_reset, asynchronous, active-high.
- Reset values:
  - shadow mask and tx snapshot all 0
  - word counter 0, pending 0, state IDLE
  - m_axis_select_tvalid = 0, tdata = 0, tlast = 0, busy = 0
- Shadow mask (2^CHAN_WIDTH bits):
  - bit_wr_valid writes bit_wr_value to bit bit_wr_chan on that clock.
  - Writes are always accepted, including during SEND.
  - Writes never alter the snapshot being transmitted.
- Snapshot rule: a commit captures the shadow value including any bit write in the same cycle.
- States:
  - IDLE, commit=1:
    - snapshot <= shadow (incl. concurrent write), counter <= 0, go to SEND.
    - tvalid = 1 on the next cycle, so latency commit -> first word is 1 clk.
  - SEND:
    - tdata = snapshot[32*cnt+31 : 32*cnt]; tlast = (cnt == NUM_WORDS-1).
    - tvalid stays 1 for the whole packet; no bubbles are inserted.
    - tdata, tlast and tvalid are registered outputs and must stay stable while tvalid=1 and tready=0.
    - Beat accepted when tvalid & tready; counter increments.
  - SEND, last beat accepted:
    - pending=0: go to IDLE; tvalid = 0 next cycle.
    - pending=1: snapshot <= shadow at that cycle, counter <= 0, pending <= 0, stay in SEND. Word 0 of the new packet is presented on the next cycle (back-to-back, no gap).
- Commit during SEND:
  - Sets pending. Multiple commits collapse into one.
  - The current packet is never truncated or restarted.
  - A commit coinciding with the last-beat accept also counts as pending: that cycle's shadow is re-sent.
- busy = (state==SEND) | pending.
- Counter width is CHAN_WIDTH-5; wrap from NUM_WORDS-1 to 0 only at tlast accept.
- Reset mid-packet: output drops immediately (async) to tvalid=0, and all state clears. The downstream receiver must then be re-synchronised by a full packet.

Optional Feature:
- Macro: SELECT_MASK_TX_CLEAR_ALL_EN.
- Defined:
  - Adds input port clear_all (1 bit).
  - clear_all=1 zeroes the entire shadow mask in one clock.
  - bit_wr_valid in the same cycle takes priority for its single bit, applied after the clear.
  - The snapshot is unaffected.
- Not defined: the port is absent and the shadow is cleared only by reset.

Test Plan:
- Reset, write chan 0=1, 33=1, 2047=1, commit; tready held 1 → 64 consecutive beats starting 1 clk after commit: word0=0x00000001, word1=0x00000002, word63=0x80000000, others 0; tlast only on beat 63; busy falls after the last beat.
- Same mask, tready toggled 1/0 each cycle → data/tlast held stable while stalled; 64 beats total; contents identical to the previous test.
- Commit at beat 10, write chan 64=1, commit again at beat 20 → first packet unchanged (bit 64=0). A second packet follows with no gap after tlast, word2=0x00000001. Exactly 2 packets in total.
- Write chan 5=1 and commit in the same cycle from IDLE → word0=0x00000020.
- Assert sync_reset at beat 30 → tvalid=0 immediately. Then commit with no writes → 64 zero words, tlast on beat 63.
- With SELECT_MASK_TX_CLEAR_ALL_EN: set chans 1 and 40, then clear_all with concurrent write chan 7=1, commit → word0=0x00000080, word1=0.
